// File: rtl/rv3n_func_wb.sv
// Writeback collector: merges single-cycle ALU results with buffered
// multiply/divide results onto the single register-file write port.
`ifndef XLEN
`define XLEN 32
`endif

module rv3n_func_wb #(
  parameter int MD_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = `XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            func_op_req_valid,
  input  logic [4:0]      func_op_req_rd,
  input  logic            func_op_ack_valid,
  input  logic [XLEN-1:0] func_op_ack_data,
  input  logic            func_md_ack_valid,
  input  logic [4:0]      func_md_ack_rd,
  input  logic [XLEN-1:0] func_md_ack_data,
  output logic            func_md_ack_ready,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_op_hold,
  output logic            wb_md_pending
);

  localparam int AW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      r_op_rd;
  logic [4:0]      r_md_rd   [MD_DEPTH];
  logic [XLEN-1:0] r_md_data [MD_DEPTH];
  logic [AW-1:0]   r_rptr;
  logic [AW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_op_hold;
  logic            r_md_pending;

  logic            w_ready;
  logic            w_push;
  logic            w_has;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;
  logic [SW-1:0]   w_starve_nxt;

  // Ready looks only at occupancy, so a same-cycle pop never frees a slot early.
  assign w_ready = (r_count < CW'(MD_DEPTH));
  assign w_push  = func_md_ack_valid & w_ready & (func_md_ack_rd != 5'd0);
  assign w_has   = (r_count != '0);
  assign w_pop   = ~func_op_ack_valid & w_has;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // Counts cycles the queued head loses to the ALU; saturates so a late ALU ack keeps the hold up.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || !w_has)
      w_starve_nxt = '0;
    else if (func_op_ack_valid && (r_starve != SW'(STARVE_LIMIT)))
      w_starve_nxt = r_starve + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_rd <= 5'd0;
    end else if (func_op_req_valid) begin
      r_op_rd <= func_op_req_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_md_rd[r_wptr]   <= func_md_ack_rd;
      r_md_data[r_wptr] <= func_md_ack_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_starve     <= '0;
      r_op_hold    <= 1'b0;
      r_md_pending <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count      <= w_count_nxt;
      r_starve     <= w_starve_nxt;
      r_op_hold    <= (r_starve == SW'(STARVE_LIMIT));
      r_md_pending <= (w_count_nxt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
    end else if (func_op_ack_valid) begin
      r_wb_valid <= (r_op_rd != 5'd0);
      r_wb_rd    <= r_op_rd;
      r_wb_data  <= func_op_ack_data;
    end else if (w_pop) begin
      r_wb_valid <= 1'b1;
      r_wb_rd    <= r_md_rd[r_rptr];
      r_wb_data  <= r_md_data[r_rptr];
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  assign func_md_ack_ready = w_ready;
  assign wb_valid          = r_wb_valid;
  assign wb_rd             = r_wb_rd;
  assign wb_data           = r_wb_data;
  assign wb_op_hold        = r_op_hold;
  assign wb_md_pending     = r_md_pending;

endmodule
